// File: rtl/regfile_write_demux_if.sv
// Write-request handshake bundle for the register-file write side.
// Master drives the request, slave answers with ready.
interface regfile_write_demux_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/regfile_write_demux.sv
// Buffered register-file write port: FIFO of requests, 1-to-NREGS demux, array.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_write_demux #(
  parameter int WIDTH     = 32,
  parameter int NREGS     = 32,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_demux_if.slave   wr,
  input  logic                   wr_hold,
  output logic [NREGS-1:0]       wr_en_onehot,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic [1:0]             buf_count,
  output logic                   busy
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [ADDR_W-1:0] baddr_q [BUF_DEPTH];
  logic [WIDTH-1:0]  bdata_q [BUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [NREGS-1:0]  onehot_q;
  logic [WIDTH-1:0]  regs_q [NREGS];

  logic              push;
  logic              pop;
  logic              keep;
  logic [ADDR_W-1:0] head_addr;
  logic [WIDTH-1:0]  head_data;
  logic [NREGS-1:0]  dec;

  assign wr.wr_ready = !reset && (cnt_q != FULL_CNT);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = (cnt_q != 2'd0) && !wr_hold;
  assign head_addr   = baddr_q[head_q];
  assign head_data   = bdata_q[head_q];
  assign dec         = NREGS'(1) << head_addr;

`ifdef REGFILE_R0_ZERO_EN
  assign keep = (head_addr != '0);
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push)
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    if (pop)
      head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      baddr_q[tail_q] <= wr.wr_addr;
      bdata_q[tail_q] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      onehot_q <= '0;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (pop && keep) begin
        regs_q[head_addr] <= head_data;
        onehot_q          <= dec;
      end else begin
        onehot_q <= '0;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign wr_en_onehot = onehot_q;
  assign buf_count    = cnt_q;
  assign busy         = (cnt_q != 2'd0);

endmodule
